sum_accumulator: RTL and testbench

//  Downstream consumer of the registered adder stage. Accumulates a programmed number
//  of WIDTH-bit sum samples into a wider total and offers the result on a valid/ready

---
 rtl/sum_accumulator.sv | 102 ++++++++++
 tb/tb_sum_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Burst accumulator behind the registered adder stage: sums a programmed number
// of unsigned samples and presents the total on a valid/ready output.
module sum_accumulator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned ACC_W = WIDTH + CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_total,
    input  logic             out_ready,
    output logic             busy,
    output logic             drop_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_nxt;
    logic [ACC_W-1:0] total_nxt;
    logic             drop_nxt;

    // State register plus registered datapath and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            out_total <= '0;
            drop_err  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= remaining_nxt;
            out_total <= total_nxt;
            drop_err  <= drop_nxt;
            // Status flags decoded from the next state so they track the state register.
            in_ready  <= (state_nxt == ACCUM);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        remaining_nxt = remaining;
        total_nxt     = out_total;
        drop_nxt      = drop_err;

        // A sample offered while not accepting is lost and flagged.
        if (in_valid && !in_ready) begin
            drop_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_nxt     = ACCUM;
                    acc_nxt       = '0;
                    remaining_nxt = len;
                    drop_nxt      = 1'b0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_nxt       = acc + ACC_W'(in_sum);
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        total_nxt = acc + ACC_W'(in_sum);
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: table of bursts plus hand-written
// sequences for backpressure, ignored starts and mid-burst reset.
module tb_sum_accumulator;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = WIDTH + CNT_W;

    logic             clk;
    logic             rstn;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_sum;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_total;
    logic             out_ready;
    logic             busy;
    logic             drop_err;

    int tests;
    int fails;

    typedef struct {
        int              len;
        logic [15:0][7:0] s;
        int              gap;
        int              total;
    } vec_t;

    vec_t vecs[5];

    sum_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_total (out_total),
        .out_ready (out_ready),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t make_vec(input int n, input int a, input int b,
                                      input int c, input int d, input int fill,
                                      input int gap, input int total);
        vec_t v;
        v.len = n;
        v.gap = gap;
        v.total = total;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0: v.s[i] = 8'(a);
                1: v.s[i] = 8'(b);
                2: v.s[i] = 8'(c);
                3: v.s[i] = 8'(d);
                default: v.s[i] = 8'(fill);
            endcase
        end
        return v;
    endfunction

    // Starts a burst, feeds its samples, checks the result and completes the handshake.
    task automatic run_burst(input vec_t v, input string tag);
        start = 1'b1;
        len   = CNT_W'(v.len);
        tick();
        start = 1'b0;
        check({tag, " busy after start"}, int'(busy), 1);
        check({tag, " in_ready after start"}, int'(in_ready), 1);
        for (int i = 0; i < v.len; i++) begin
            in_valid = 1'b1;
            in_sum   = v.s[i];
            tick();
            in_valid = 1'b0;
            if (i < v.len - 1) begin
                if (i == 0) check({tag, " no early out_valid"}, int'(out_valid), 0);
                if (v.gap != 0) begin
                    for (int g = 0; g < (i % 4); g++) tick();
                end
            end
        end
        check({tag, " out_valid"}, int'(out_valid), 1);
        check({tag, " out_total"}, int'(out_total), v.total);
        check({tag, " in_ready in DONE"}, int'(in_ready), 0);
        tick();
        check({tag, " out_total held"}, int'(out_total), v.total);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, int'(out_valid), 0);
        check({tag, " busy cleared"}, int'(busy), 0);
        check({tag, " out_total kept"}, int'(out_total), v.total);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rstn      = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;

        vecs[0] = make_vec(3, 10, 20, 30, 0, 0, 0, 60);
        vecs[1] = make_vec(15, 255, 255, 255, 255, 255, 0, 3825);
        vecs[2] = make_vec(4, 1, 2, 3, 4, 0, 1, 10);
        vecs[3] = make_vec(2, 7, 8, 0, 0, 0, 0, 15);
        vecs[4] = make_vec(1, 200, 0, 0, 0, 0, 0, 200);

        tick();
        tick();
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_total", int'(out_total), 0);
        check("reset busy", int'(busy), 0);
        check("reset drop_err", int'(drop_err), 0);
        rstn = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            run_burst(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure in DONE with samples still arriving.
        start = 1'b1; len = CNT_W'(2); tick(); start = 1'b0;
        in_valid = 1'b1; in_sum = 8'd5; tick();
        in_sum = 8'd6; tick();
        in_sum = 8'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold out_valid", int'(out_valid), 1);
            check("hold out_total", int'(out_total), 11);
        end
        in_valid = 1'b0;
        check("drop_err set", int'(drop_err), 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("drop_err sticky in IDLE", int'(drop_err), 1);
        start = 1'b1; len = CNT_W'(1); tick(); start = 1'b0;
        check("drop_err cleared by start", int'(drop_err), 0);
        in_valid = 1'b1; in_sum = 8'd4; tick(); in_valid = 1'b0;
        check("post-drop total", int'(out_total), 4);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Zero-length start is ignored.
        start = 1'b1; len = '0; tick(); start = 1'b0;
        check("len0 busy", int'(busy), 0);
        check("len0 in_ready", int'(in_ready), 0);

        // Start during ACCUM must not reload the remaining count.
        start = 1'b1; len = CNT_W'(3); tick(); start = 1'b0;
        in_valid = 1'b1; in_sum = 8'd1; tick(); in_valid = 1'b0;
        start = 1'b1; len = CNT_W'(9); tick(); start = 1'b0;
        in_valid = 1'b1; in_sum = 8'd2; tick();
        check("restart ignored no done yet", int'(out_valid), 0);
        in_sum = 8'd3; tick(); in_valid = 1'b0;
        check("restart ignored out_valid", int'(out_valid), 1);
        check("restart ignored total", int'(out_total), 6);
        // start coinciding with the handshake is also ignored.
        out_ready = 1'b1; start = 1'b1; len = CNT_W'(2); tick();
        out_ready = 1'b0; start = 1'b0;
        check("start at handshake busy", int'(busy), 0);
        tick();
        check("start at handshake stays idle", int'(busy), 0);

        // Asynchronous reset mid-burst.
        start = 1'b1; len = CNT_W'(5); tick(); start = 1'b0;
        in_valid = 1'b1; in_sum = 8'd50; tick();
        in_sum = 8'd60; tick(); in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("async rst busy", int'(busy), 0);
        check("async rst in_ready", int'(in_ready), 0);
        check("async rst out_valid", int'(out_valid), 0);
        check("async rst out_total", int'(out_total), 0);
        check("async rst drop_err", int'(drop_err), 0);
        tick();
        rstn = 1'b1;
        tick();
        run_burst(vecs[3], "after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
